// File: rtl/wb_arb5_rr.sv
// ---------------------------------------------------------------------------
// wb_arb5_rr
// Registered round-robin arbiter for a 5-master Wishbone switch. It produces
// the 3-bit grant select that steers the switch's master mux.
//   - The grant is held for the owner's whole cycle (cyc). An incrementing or
//     constant-address burst is never split.
//   - Optional fairness pre-emption (MAX_HOLD acks per tenure). It is taken
//     only at a single-transfer or end-of-burst ack, and only when another
//     master is waiting.
//   - Optional stall watchdog (TIMEOUT cycles of strobe without ack). It
//     force-releases the owner, which is re-queued if it still holds cyc.
//
// Parameters
//   MAX_HOLD  0..255  acks per tenure before a boundary pre-emption (0 = off)
//   TIMEOUT   0..255  stalled strobe cycles before forced release (0 = off)
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   req_i[4:0] in   per-master cyc
//   stb_i[4:0] in   per-master stb
//   cti_i[2:0] in   cti of the currently granted master (muxed by switch)
//   ack_i      in   shared ack from the switch
//   gnt_o[2:0] out  granted master index 0..4 (registered, parked when idle)
//   gnt_vld_o  out  owner on gnt_o holds a live tenure
//   preempt_o  out  pulse: fairness pre-emption taken this cycle
//   timeout_o  out  pulse: watchdog fired this cycle
// ---------------------------------------------------------------------------
module wb_arb5_rr #(
    parameter int MAX_HOLD = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [4:0] req_i,
    input  logic [4:0] stb_i,
    input  logic [2:0] cti_i,
    input  logic       ack_i,
    output logic [2:0] gnt_o,
    output logic       gnt_vld_o,
    output logic       preempt_o,
    output logic       timeout_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    localparam logic       MH_EN   = (MAX_HOLD > 0);
    localparam logic       TO_EN   = (TIMEOUT > 0);
    localparam logic [8:0] MH_LIM  = 9'(MAX_HOLD);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_gnt;
    logic [2:0] r_last;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_wd_cnt;

    logic [2:0] w_gnt_next;
    logic [2:0] w_last_next;
    logic [7:0] w_hold_next;
    logic [7:0] w_wd_next;

    logic [4:0] w_owner_sel;
    logic       w_in_grant;
    logic       w_owner_req;
    logic       w_owner_stb;
    logic [4:0] w_cand;
    logic       w_any_cand;
    logic [2:0] w_pick;
    logic       w_cti_boundary;
    logic       w_stall;
    logic       w_release;
    logic       w_timeout_hit;
    logic       w_hold_reached;
    logic       w_preempt_hit;
    logic       w_vacate;
    logic       w_move;

    // One-hot decode of the current owner, used for masking and selection.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_owner_sel
            assign w_owner_sel[gi] = (r_gnt == 3'(gi));
        end
    endgenerate

    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_owner_req = |(req_i & w_owner_sel);
    assign w_owner_stb = |(stb_i & w_owner_sel);

    // While a tenure is live the owner never competes in its own pick; from
    // IDLE the parked index (== last) is a normal candidate at the last step.
    assign w_cand     = w_in_grant ? (req_i & ~w_owner_sel) : req_i;
    assign w_any_cand = |w_cand;

    // Round-robin search from last+1, wrapping 4->0. Scanning from the far end
    // downwards lets the nearest candidate overwrite the result last.
    always_comb begin
        logic [3:0] v_sum;
        logic [2:0] v_idx;
        logic [7:0] v_cand8;
        v_cand8 = {3'b000, w_cand};
        v_sum   = '0;
        v_idx   = '0;
        w_pick  = r_last;
        for (int k = 5; k >= 1; k--) begin
            v_sum = {1'b0, r_last} + 4'(k);
            v_idx = (v_sum >= 4'd5) ? 3'(v_sum - 4'd5) : v_sum[2:0];
            if (v_cand8[v_idx]) begin
                w_pick = v_idx;
            end
        end
    end

    // Only single transfers and the last beat of a burst are safe cut points.
    assign w_cti_boundary = (cti_i == 3'b000) || (cti_i == 3'b111);
    assign w_stall        = w_in_grant & w_owner_stb & ~ack_i;

    // Action priority: release > timeout > pre-empt > hold. Dropping cyc in
    // the same cycle suppresses both pulses.
    assign w_release      = w_in_grant & ~w_owner_req;
    assign w_timeout_hit  = TO_EN & w_in_grant & w_owner_req & w_stall
                          & (r_wd_cnt == TO_LAST);
    assign w_hold_reached = (({1'b0, r_hold_cnt} + 9'd1) >= MH_LIM);
    assign w_preempt_hit  = MH_EN & w_in_grant & w_owner_req & ~w_timeout_hit
                          & ack_i & w_cti_boundary & w_hold_reached & w_any_cand;

    assign w_vacate = w_release | w_timeout_hit;
    assign w_move   = w_any_cand & (~w_in_grant | w_vacate | w_preempt_hit);

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 3'd0;
            r_last     <= 3'd4;
            r_hold_cnt <= 8'd0;
            r_wd_cnt   <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_last     <= w_last_next;
            r_hold_cnt <= w_hold_next;
            r_wd_cnt   <= w_wd_next;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = (|req_i) ? ST_GRANT : ST_IDLE;
            ST_GRANT: w_state_next = (w_vacate && !w_any_cand) ? ST_IDLE : ST_GRANT;
            default:  w_state_next = ST_IDLE;
        endcase

        w_gnt_next  = w_move ? w_pick : r_gnt;
        w_last_next = w_move ? w_pick : r_last;

        if (w_move || w_state_next == ST_IDLE) begin
            w_hold_next = 8'd0;
        end else if (ack_i && r_hold_cnt != 8'hFF) begin
            w_hold_next = r_hold_cnt + 8'd1;
        end else begin
            w_hold_next = r_hold_cnt;
        end

        if (w_move || w_state_next == ST_IDLE || w_timeout_hit || !w_stall) begin
            w_wd_next = 8'd0;
        end else if (r_wd_cnt != 8'hFF) begin
            w_wd_next = r_wd_cnt + 8'd1;
        end else begin
            w_wd_next = r_wd_cnt;
        end
    end

    // Outputs: grant comes straight from registers; pulses flag the action
    // being taken in the current cycle.
    always_comb begin
        gnt_o     = r_gnt;
        gnt_vld_o = (r_state == ST_GRANT);
        preempt_o = w_preempt_hit;
        timeout_o = w_timeout_hit;
    end

endmodule
